// File: rtl/sc_regbackg_pkg.sv
// Shared constants and helpers for the background matrix register and its row scanner.
// Optional scroll mode is selected in the top level by SC_REGBACKG_SCROLL_EN.
package sc_regbackg_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ROWS      = 8;
  localparam int DEF_SCAN_DIV  = 50000;

  // Widest row-select the decode helper supports.
  localparam int MAX_ROWS = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_ROWS-1:0] row_onehot(input int unsigned idx);
    return MAX_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/sc_regbackg_scan.sv
// Row scanner: prescaler, active-row counter and a registered one-cycle frame-wrap pulse.
// Independent of the matrix strobes; only reset restarts it.
module sc_regbackg_scan
  import sc_regbackg_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int RW       = idx_width(ROWS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [RW-1:0] o_scan_row,
  output logic          o_frame_done
);

  localparam int DW = idx_width(SCAN_DIV);

  logic [DW-1:0] r_div;
  logic [RW-1:0] r_scan_row;
  logic          r_frame_done;
  logic          w_tick;
  logic          w_wrap;

  assign w_tick = (r_div == DW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_scan_row == RW'(ROWS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div        <= '0;
      r_scan_row   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div      <= '0;
        r_scan_row <= r_scan_row + 1'b1;  // ROWS is a power of two, so this wraps naturally
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_frame_done <= w_wrap;
    end
  end

  assign o_scan_row   = r_scan_row;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/sc_regbackg.sv
// Background image register (ROWS x DATAWIDTH) with active-low clear/load strobes and row scan-out.
// Define SC_REGBACKG_SCROLL_EN to make load shift the image down instead of writing at wptr.
module sc_regbackg
  import sc_regbackg_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ROWS      = DEF_ROWS,
  parameter int SCAN_DIV  = DEF_SCAN_DIV
) (
  input  logic                 SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic                 SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic                 SC_REGBACKG_clear_InLow,
  input  logic                 SC_REGBACKG_load_InLow,
  input  logic [DATAWIDTH-1:0] SC_REGBACKG_data_InBUS,
  output logic [ROWS-1:0]      SC_REGBACKG_row_OutBUS,
  output logic [DATAWIDTH-1:0] SC_REGBACKG_col_OutBUS,
  output logic                 SC_REGBACKG_frameDone_Out
);

  localparam int RW = idx_width(ROWS);

  logic [DATAWIDTH-1:0] r_matrix [ROWS];
  logic [RW-1:0]        w_scan_row;
  logic                 w_frame_done;

`ifndef SC_REGBACKG_SCROLL_EN
  logic [RW-1:0]        r_wptr;
`endif

  // Clear wins over load when both strobes are low in the same cycle.
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      for (int i = 0; i < ROWS; i++) r_matrix[i] <= '0;
`ifndef SC_REGBACKG_SCROLL_EN
      r_wptr <= '0;
`endif
    end else if (!SC_REGBACKG_clear_InLow) begin
      for (int i = 0; i < ROWS; i++) r_matrix[i] <= '0;
`ifndef SC_REGBACKG_SCROLL_EN
      r_wptr <= '0;
`endif
    end else if (!SC_REGBACKG_load_InLow) begin
`ifdef SC_REGBACKG_SCROLL_EN
      for (int i = ROWS - 1; i >= 1; i--) r_matrix[i] <= r_matrix[i-1];
      r_matrix[0] <= SC_REGBACKG_data_InBUS;
`else
      r_matrix[r_wptr] <= SC_REGBACKG_data_InBUS;
      r_wptr           <= r_wptr + 1'b1;
`endif
    end
  end

  sc_regbackg_scan #(
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV),
    .RW       (RW)
  ) u_scan (
    .i_clk        (SC_STATEMACHINEBACKG_CLOCK_50),
    .i_rst        (SC_STATEMACHINEBACKG_RESET_InHigh),
    .o_scan_row   (w_scan_row),
    .o_frame_done (w_frame_done)
  );

  assign SC_REGBACKG_row_OutBUS    = ROWS'(row_onehot(32'(w_scan_row)));
  assign SC_REGBACKG_col_OutBUS    = r_matrix[w_scan_row];
  assign SC_REGBACKG_frameDone_Out = w_frame_done;

endmodule

// File: tb/tb_sc_regbackg.sv
// Self-checking bench for sc_regbackg (ROWS=8, DATAWIDTH=8, SCAN_DIV=4).
// Honours SC_REGBACKG_SCROLL_EN so the same bench covers both builds.
module tb_sc_regbackg;

  localparam int DWID = 8;
  localparam int NROW = 8;
  localparam int SDIV = 4;
  localparam int EW   = NROW + DWID + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear_n = 1'b1;
  logic            load_n = 1'b1;
  logic [DWID-1:0] data = '0;
  logic [NROW-1:0] row_out;
  logic [DWID-1:0] col_out;
  logic            frame_out;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DWID-1:0] m_mat [NROW];
  int              m_wptr;
  int              m_n;
  logic [EW-1:0]   exp_q[$];

  typedef struct {
    logic            clr_n;
    logic            ld_n;
    logic [DWID-1:0] dat;
    bit              chk;
    int              row;
    logic [DWID-1:0] val;
  } vec_t;

  vec_t tbl[$];

  sc_regbackg #(
    .DATAWIDTH (DWID),
    .ROWS      (NROW),
    .SCAN_DIV  (SDIV)
  ) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50     (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh (rst),
    .SC_REGBACKG_clear_InLow           (clear_n),
    .SC_REGBACKG_load_InLow            (load_n),
    .SC_REGBACKG_data_InBUS            (data),
    .SC_REGBACKG_row_OutBUS            (row_out),
    .SC_REGBACKG_col_OutBUS            (col_out),
    .SC_REGBACKG_frameDone_Out         (frame_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NROW; i++) m_mat[i] = '0;
    m_wptr = 0;
    m_n    = 0;
    exp_q.delete();
  endtask

  // Called at a negedge: hold reset for one active edge, check, release.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_row", 32'(row_out), 32'h01);
    check("reset_col", 32'(col_out), 32'h00);
    check("reset_frame", 32'(frame_out), 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic c, input logic l, input logic [DWID-1:0] d);
    int r;
    logic [NROW-1:0] er;
    clear_n = c;
    load_n  = l;
    data    = d;
    @(posedge clk);
    if (!c) begin
      for (int i = 0; i < NROW; i++) m_mat[i] = '0;
      m_wptr = 0;
    end else if (!l) begin
`ifdef SC_REGBACKG_SCROLL_EN
      for (int i = NROW - 1; i >= 1; i--) m_mat[i] = m_mat[i-1];
      m_mat[0] = d;
`else
      m_mat[m_wptr] = d;
      m_wptr = (m_wptr + 1) % NROW;
`endif
    end
    m_n++;
    r  = (m_n / SDIV) % NROW;
    er = NROW'(1) << r;
    exp_q.push_back({er, m_mat[r], (m_n > 0) && (m_n % (SDIV * NROW) == 0)});
    @(negedge clk);
    clear_n = 1'b1;
    load_n  = 1'b1;
  endtask

  // Idle until row r is scanned (bounded), then compare its contents.
  task automatic read_row(input int r, input logic [DWID-1:0] v);
    int k;
    logic [NROW-1:0] want;
    want = NROW'(1) << r;
    k = 0;
    while (row_out !== want && k < 2 * SDIV * NROW) begin
      step(1'b1, 1'b1, '0);
      k++;
    end
    check($sformatf("row%0d_reached", r), 32'(row_out), 32'(want));
    check($sformatf("row%0d_data", r), 32'(col_out), 32'(v));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_row", 32'(row_out), 32'(e[EW-1 -: NROW]));
      check("sb_col", 32'(col_out), 32'(e[DWID:1]));
      check("sb_frame", 32'(frame_out), 32'(e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int pulses;

`ifdef SC_REGBACKG_SCROLL_EN
    tbl.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 8'h11, 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 8'h22, 1'b1, 0, 8'h22});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1, 8'h11});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 2, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 7, 8'h00});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 1'b1, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1, 8'h00});
    for (int i = 1; i <= 9; i++) tbl.push_back('{1'b1, 1'b0, 8'(i), 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 0, 8'h09});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 7, 8'h02});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 3, 8'h06});
`else
    tbl.push_back('{1'b1, 1'b0, 8'hA5, 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 8'h3C, 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 8'hFF, 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 0, 8'hA5});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 2, 8'hFF});
    tbl.push_back('{1'b1, 1'b0, 8'h77, 1'b1, 3, 8'h77});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 1'b1, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 3, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 8'h5A, 1'b1, 0, 8'h5A});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 0, 8'h00});
    for (int i = 1; i <= 8; i++) tbl.push_back('{1'b1, 1'b0, 8'(i), 1'b0, 0, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 8'h09, 1'b1, 0, 8'h09});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1, 8'h02});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 7, 8'h08});
    tbl.push_back('{1'b1, 1'b0, 8'hAA, 1'b1, 1, 8'hAA});
`endif

    model_reset();
    @(negedge clk);
    do_reset();

    // One full frame of idle: exactly one frameDone pulse, at clock 32
    pulses = 0;
    for (int i = 0; i < SDIV * NROW + 4; i++) begin
      step(1'b1, 1'b1, '0);
      if (frame_out === 1'b1) pulses++;
      if (m_n == SDIV * NROW) check("wrap_row", 32'(row_out), 32'h01);
    end
    check("frame_pulse_count", 32'(pulses), 32'd1);

    // Table-driven strobe vectors
    foreach (tbl[i]) begin
      step(tbl[i].clr_n, tbl[i].ld_n, tbl[i].dat);
      if (tbl[i].chk) read_row(tbl[i].row, tbl[i].val);
    end

    // Reset mid-frame while row 5 is active
    step(1'b1, 1'b0, 8'hC3);
    cnt = 0;
    while (row_out !== 8'h20 && cnt < 2 * SDIV * NROW) begin
      step(1'b1, 1'b1, '0);
      cnt++;
    end
    check("midframe_row5_reached", 32'(row_out), 32'h20);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_row", 32'(row_out), 32'h01);
    check("midframe_rst_col", 32'(col_out), 32'h00);
    check("midframe_rst_frame", 32'(frame_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int r = 0; r < NROW; r++) read_row(r, 8'h00);

    // Reset right after the wrap edge cancels the pending frameDone
    model_reset();
    do_reset();
    cnt = 0;
    while (m_n < SDIV * NROW && cnt < 4 * SDIV * NROW) begin
      step(1'b1, 1'b1, '0);
      cnt++;
    end
    check("pending_frame_high", 32'(frame_out), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("pending_frame_cancel", 32'(frame_out), 32'h0);
    check("pending_rst_row", 32'(row_out), 32'h01);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < SDIV + 2; i++) step(1'b1, 1'b1, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_regbackg.md
# sc_regbackg

Background matrix register and row scanner that sits on the receiving end of the background state machine's active-low clear/load strobes. It holds an ROWS x DATAWIDTH background image, applies clear and load strobes one operation per sampled clock, and continuously scans the image out row by row to the LED-matrix driver. It reports each completed scan frame.

## Interface
- DATAWIDTH, 8, bits per row (column count)
- ROWS, 8, number of rows; power of two, ≥2
- SCAN_DIV, 50000, clocks per scanned row; ≥1
- SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock
- SC_STATEMACHINEBACKG_RESET_InHigh  in  1  reset, asynchronous, active-high
- SC_REGBACKG_clear_InLow  in  1  clear strobe, active-low, synchronous to clock
- SC_REGBACKG_load_InLow  in  1  load strobe, active-low, synchronous to clock
- SC_REGBACKG_data_InBUS  in  DATAWIDTH  row pattern for load
- SC_REGBACKG_row_OutBUS  out  ROWS  one-hot active row select
- SC_REGBACKG_col_OutBUS  out  DATAWIDTH  contents of active row
- SC_REGBACKG_frameDone_Out  out  1  one-cycle pulse at frame wrap

## Operation
- Storage: matrix[ROWS][DATAWIDTH], write pointer wptr (log2 ROWS bits).
- Strobes are level-sampled on every rising clock edge; every cycle a strobe is low is one operation.
- Clear (clear_InLow=0): all rows ← 0, wptr ← 0.
- Load (load_InLow=0, clear_InLow=1): behaviour per Configuration.
- Clear and load both low in one cycle: clear only; load is discarded.
- Neither low: matrix and wptr hold.
- Scan: prescaler divCnt counts 0..SCAN_DIV-1. At divCnt=SCAN_DIV-1, divCnt ← 0 and scanRow ← scanRow+1 mod ROWS. SCAN_DIV=1 advances every cycle.
- row_OutBUS = one-hot(scanRow); col_OutBUS = matrix[scanRow]. Both are combinational from registers.
- frameDone_Out is registered. It goes high for exactly one cycle after the edge where scanRow wraps ROWS-1→0.
- Strobes never disturb the scanner. Clear/load do not reset divCnt or scanRow.

## Timing
- Reset (async assert): matrix=0, wptr=0, divCnt=0, scanRow=0 → row_OutBUS=…0001, col_OutBUS=0, frameDone_Out=0.
- Reset release: first scan advance happens SCAN_DIV edges later.
- Write latency: a strobe sampled at edge k is visible on col_OutBUS after edge k, provided that row is the active one.
- Wrap-around: wptr at ROWS-1 plus one load → 0. No full/overflow flag; old rows are overwritten.
- Reset mid-frame: the scanner restarts at row 0 and any pending frameDone is cancelled.

## Configuration
- Macro SC_REGBACKG_SCROLL_EN.
- Defined: load shifts the image down one row (matrix[i] ← matrix[i-1] for i≥1, matrix[0] ← data_InBUS) and wptr is unused (held 0). Row ROWS-1 is discarded.
- Undefined: load writes matrix[wptr] ← data_InBUS and wptr ← wptr+1 mod ROWS.

## Structure
- Package sc_regbackg_pkg: default DATAWIDTH/ROWS/SCAN_DIV constants, a row-index width function (clog2), and the one-hot row decode function.
- One sub-module: sc_regbackg_scan. It contains the prescaler, scanRow counter and frameDone pulse generator, and exports scanRow and frameDone.
- The top level holds the matrix, wptr, strobe priority logic and output muxing.

## Test plan
- Reset with SCAN_DIV=4, ROWS=8 → row_OutBUS=8'h01, col_OutBUS=0; after 32 clocks frameDone_Out pulses once (1 cycle); row_OutBUS returns to 8'h01.
- Non-scroll build, loads of 8'hA5, 8'h3C, 8'hFF on consecutive cycles → rows 0/1/2 read A5/3C/FF while scanned; wptr=3.
- Non-scroll build, 9 loads 8'h01..8'h09 → row 0 reads 8'h09 (wrap); row 1 reads 8'h02.
- Clear and load low together with data 8'hFF → all rows read 0 next cycle; wptr=0.
- Scroll build, loads 8'h11 then 8'h22 → row 0=8'h22, row 1=8'h11, others 0.
- Assert reset mid-frame while scanRow=5 → same cycle row_OutBUS=8'h01, all rows 0, no frameDone pulse.
